// File: rtl/paddle_ctrl.sv
// paddle_ctrl: conditions the six raw player buttons (2-flop synchronizer,
// debouncer, serve-button rising-edge pulse) and moves both paddles on a
// rate-divided tick, clamped to the playfield. GAME_OVER recentres and
// freezes both paddles.
// Optional build macro: PADDLE_ACCEL_EN adds hold-to-accelerate: after
// ACCEL_TICKS consecutive single-direction ticks the step becomes 2.
module paddle_ctrl #(
    parameter int SCR_H        = 20,
    parameter int PADDLE_H     = 6,
    parameter int DEBOUNCE_CYC = 750000,
    parameter int MOVE_DIV     = 3750000
`ifdef PADDLE_ACCEL_EN
    ,
    parameter int ACCEL_TICKS  = 8
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_UP_RAW,
    input  logic        A_DOWN_RAW,
    input  logic        BTN_A_RAW,
    input  logic        B_UP_RAW,
    input  logic        B_DOWN_RAW,
    input  logic        BTN_B_RAW,
    input  logic        GAME_OVER,
    output logic        A_UP,
    output logic        A_DOWN,
    output logic        B_UP,
    output logic        B_DOWN,
    output logic        BUTTON_A,
    output logic        BUTTON_B,
    output logic [10:0] L_PADDLE_POSITION,
    output logic [10:0] R_PADDLE_POSITION
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC);
    localparam int DIV_W = $clog2(MOVE_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
    localparam logic [10:0]      CENTER   = 11'((SCR_H - PADDLE_H) / 2);
    localparam logic [10:0]      MAXPOS   = 11'(SCR_H - PADDLE_H);

    // Bit positions shared by every per-button vector below.
    localparam int I_A_UP = 0;
    localparam int I_A_DN = 1;
    localparam int I_A_SV = 2;
    localparam int I_B_UP = 3;
    localparam int I_B_DN = 4;
    localparam int I_B_SV = 5;

    logic [5:0]           raw_in;
    logic [5:0]           sync1_q, sync1_d;
    logic [5:0]           sync2_q, sync2_d;
    logic [5:0]           db_q, db_d;
    logic [5:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           serve_prev_q, serve_prev_d;
    logic [1:0]           serve_pulse_q, serve_pulse_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;
    logic [1:0][10:0]     pos_q, pos_d;
    logic [1:0]           up_v, dn_v;
    logic [1:0][10:0]     step_v;

    assign raw_in = {BTN_B_RAW, B_DOWN_RAW, B_UP_RAW, BTN_A_RAW, A_DOWN_RAW, A_UP_RAW};

    // Index 0 is the left paddle (player A), index 1 the right (player B).
    assign up_v = {db_q[I_B_UP], db_q[I_A_UP]};
    assign dn_v = {db_q[I_B_DN], db_q[I_A_DN]};

    // Two-flop synchronizer chain for the asynchronous board buttons.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    // Debouncer: the level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYC consecutive cycles; any agreement restarts.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Serve pulse: one cycle high on the cycle after a debounced 0->1 edge.
    always_comb begin
        serve_prev_d  = {db_q[I_B_SV], db_q[I_A_SV]};
        serve_pulse_d = serve_prev_d & ~serve_prev_q;
    end

    // Free-running movement tick divider, 0..MOVE_DIV-1.
    assign tick = (div_q == DIV_LAST);
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

`ifdef PADDLE_ACCEL_EN
    localparam int ACC_W = $clog2(ACCEL_TICKS + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCEL_TICKS);

    logic [1:0][ACC_W-1:0] held_q, held_d;
    logic [1:0]            dir_q, dir_d;   // 1 = last held direction was down

    // Held-tick counters: saturate at ACCEL_TICKS, restart on release or reversal.
    always_comb begin
        held_d = held_q;
        dir_d  = dir_q;
        for (int p = 0; p < 2; p++) begin
            step_v[p] = 11'd1;
            if (GAME_OVER) begin
                held_d[p] = '0;
            end else if (tick) begin
                if (up_v[p] == dn_v[p]) begin
                    held_d[p] = '0;
                end else begin
                    if (held_q[p] != '0 && dir_q[p] != dn_v[p]) begin
                        held_d[p] = '0;
                    end else if (held_q[p] == ACC_MAX) begin
                        step_v[p] = 11'd2;
                    end else begin
                        held_d[p] = held_q[p] + ACC_W'(1);
                    end
                    dir_d[p] = dn_v[p];
                end
            end
        end
    end

    // Accelerator state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            held_q <= '0;
            dir_q  <= '0;
        end else begin
            held_q <= held_d;
            dir_q  <= dir_d;
        end
    end
`else
    assign step_v = {11'd1, 11'd1};
`endif

    // Paddle movement on tick; clamp is checked before the update so the
    // 11-bit position never wraps. GAME_OVER overrides with recentring.
    always_comb begin
        pos_d = pos_q;
        for (int p = 0; p < 2; p++) begin
            if (GAME_OVER) begin
                pos_d[p] = CENTER;
            end else if (tick) begin
                if (up_v[p] && !dn_v[p]) begin
                    pos_d[p] = (pos_q[p] > step_v[p]) ? pos_q[p] - step_v[p] : 11'd1;
                end else if (dn_v[p] && !up_v[p]) begin
                    pos_d[p] = (pos_q[p] + step_v[p] <= MAXPOS) ? pos_q[p] + step_v[p] : MAXPOS;
                end
            end
        end
    end

    // Main state registers; positions reset to the centre row.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            db_q          <= '0;
            db_cnt_q      <= '0;
            serve_prev_q  <= '0;
            serve_pulse_q <= '0;
            div_q         <= '0;
            pos_q         <= {CENTER, CENTER};
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_q          <= db_d;
            db_cnt_q      <= db_cnt_d;
            serve_prev_q  <= serve_prev_d;
            serve_pulse_q <= serve_pulse_d;
            div_q         <= div_d;
            pos_q         <= pos_d;
        end
    end

    assign A_UP              = db_q[I_A_UP];
    assign A_DOWN            = db_q[I_A_DN];
    assign B_UP              = db_q[I_B_UP];
    assign B_DOWN            = db_q[I_B_DN];
    assign BUTTON_A          = serve_pulse_q[0];
    assign BUTTON_B          = serve_pulse_q[1];
    assign L_PADDLE_POSITION = pos_q[0];
    assign R_PADDLE_POSITION = pos_q[1];

endmodule

// File: tb/tb_paddle_ctrl.sv
// Testbench for paddle_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the button/paddle rules.
module tb_paddle_ctrl;

    localparam int SCR_H    = 20;
    localparam int PADDLE_H = 6;
    localparam int DB       = 4;
    localparam int MD       = 3;
`ifdef PADDLE_ACCEL_EN
    localparam int AT       = 2;
`endif
    localparam int CENTER   = (SCR_H - PADDLE_H) / 2;
    localparam int MAXPOS   = SCR_H - PADDLE_H;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_UP_RAW, A_DOWN_RAW, BTN_A_RAW;
    logic        B_UP_RAW, B_DOWN_RAW, BTN_B_RAW;
    logic        GAME_OVER;
    logic        A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B;
    logic [10:0] L_PADDLE_POSITION, R_PADDLE_POSITION;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    paddle_ctrl #(
        .SCR_H       (SCR_H),
        .PADDLE_H    (PADDLE_H),
        .DEBOUNCE_CYC(DB),
        .MOVE_DIV    (MD)
`ifdef PADDLE_ACCEL_EN
        ,
        .ACCEL_TICKS (AT)
`endif
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .A_UP_RAW         (A_UP_RAW),
        .A_DOWN_RAW       (A_DOWN_RAW),
        .BTN_A_RAW        (BTN_A_RAW),
        .B_UP_RAW         (B_UP_RAW),
        .B_DOWN_RAW       (B_DOWN_RAW),
        .BTN_B_RAW        (BTN_B_RAW),
        .GAME_OVER        (GAME_OVER),
        .A_UP             (A_UP),
        .A_DOWN           (A_DOWN),
        .B_UP             (B_UP),
        .B_DOWN           (B_DOWN),
        .BUTTON_A         (BUTTON_A),
        .BUTTON_B         (BUTTON_B),
        .L_PADDLE_POSITION(L_PADDLE_POSITION),
        .R_PADDLE_POSITION(R_PADDLE_POSITION)
    );

    // ---------------- behavioural model ----------------
    // Bits: 0 A up, 1 A down, 2 A serve, 3 B up, 4 B down, 5 B serve.
    logic [5:0] m_s1, m_s2, m_db, m_db_old;
    int         m_run [6];
    logic       m_pulse_a, m_pulse_b;
    int         m_edges, m_l, m_r;
`ifdef PADDLE_ACCEL_EN
    int         m_held [2];
    int         m_dir  [2];
`endif

    function automatic logic [5:0] raw_vec();
        return {BTN_B_RAW, B_DOWN_RAW, B_UP_RAW, BTN_A_RAW, A_DOWN_RAW, A_UP_RAW};
    endfunction

    task automatic set_raw(input logic [5:0] v);
        A_UP_RAW   = v[0];
        A_DOWN_RAW = v[1];
        BTN_A_RAW  = v[2];
        B_UP_RAW   = v[3];
        B_DOWN_RAW = v[4];
        BTN_B_RAW  = v[5];
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_db_old = '0;
        for (int i = 0; i < 6; i++) m_run[i] = 0;
        m_pulse_a = 1'b0; m_pulse_b = 1'b0;
        m_edges = 0; m_l = CENTER; m_r = CENTER;
`ifdef PADDLE_ACCEL_EN
        for (int p = 0; p < 2; p++) begin m_held[p] = 0; m_dir[p] = 0; end
`endif
    endtask

    // New position of paddle p for one tick, by the movement rules.
    function automatic int move_pos(input int p, input int pos, input logic up, input logic dn);
        int step;
        int dir;
        int np;
        step = 1;
        if (up == dn) begin
`ifdef PADDLE_ACCEL_EN
            m_held[p] = 0;
`endif
            return pos;
        end
        dir = up ? -1 : 1;
`ifdef PADDLE_ACCEL_EN
        if (m_held[p] > 0 && m_dir[p] != dir) begin
            m_held[p] = 0;
        end else if (m_held[p] == AT) begin
            step = 2;
        end else begin
            m_held[p] = m_held[p] + 1;
        end
        m_dir[p] = dir;
`endif
        np = pos + dir * step;
        if (np < 1) np = 1;
        if (np > MAXPOS) np = MAXPOS;
        return np;
    endfunction

    // Advance the model by one rising edge, given the inputs present at it.
    task automatic model_edge(input logic [5:0] raw, input logic go);
        logic [5:0] db_before;
        logic       tick;
        db_before = m_db;
        m_edges++;
        tick = (m_edges % MD) == 0;
        m_pulse_a = m_db[2] && !m_db_old[2];
        m_pulse_b = m_db[5] && !m_db_old[5];
        m_db_old  = m_db;
        if (go) begin
            m_l = CENTER;
            m_r = CENTER;
`ifdef PADDLE_ACCEL_EN
            m_held[0] = 0;
            m_held[1] = 0;
`endif
        end else if (tick) begin
            m_l = move_pos(0, m_l, db_before[0], db_before[1]);
            m_r = move_pos(1, m_r, db_before[3], db_before[4]);
        end
        for (int i = 0; i < 6; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // One clock: model follows the edge, outputs are then sampled 1 ns later.
    task automatic cycle();
        @(posedge CLK);
        model_edge(raw_vec(), GAME_OVER);
        #1;
    endtask

    task automatic do_reset();
        set_raw('0);
        GAME_OVER = 1'b0;
        #2 RST = 1'b1;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_raw('0);
        GAME_OVER = 1'b0;
        RST = 1'b1;
        #2;
        checks++;
        if (L_PADDLE_POSITION !== 11'(CENTER)) begin
            errors++; $display("FAIL reset_L: got %0d expected %0d", L_PADDLE_POSITION, CENTER);
        end
        checks++;
        if (R_PADDLE_POSITION !== 11'(CENTER)) begin
            errors++; $display("FAIL reset_R: got %0d expected %0d", R_PADDLE_POSITION, CENTER);
        end
        checks++;
        if ({A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B} !== 6'b0) begin
            errors++; $display("FAIL reset_levels: got %b expected 000000",
                               {A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B});
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        cycle();
        checks++;
        if (L_PADDLE_POSITION !== 11'(CENTER) || A_UP !== 1'b0) begin
            errors++; $display("FAIL reset_after_release: L=%0d A_UP=%b expected %0d/0",
                               L_PADDLE_POSITION, A_UP, CENTER);
        end
    endtask

    task automatic test_debounce();
        int seen;
        int rise;
        int fall;
        do_reset();
        seen = 0;
        A_UP_RAW = 1'b1;
        repeat (3) begin cycle(); if (A_UP) seen = 1; end
        A_UP_RAW = 1'b0;
        repeat (12) begin cycle(); if (A_UP) seen = 1; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL debounce_glitch: A_UP rose=%0d expected 0", seen);
        end
        rise = -1;
        A_UP_RAW = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (A_UP === 1'b1 && rise < 0) rise = k;
        end
        A_UP_RAW = 1'b0;
        checks++;
        if (rise != 2 + DB) begin
            errors++; $display("FAIL debounce_rise: edge %0d expected %0d", rise, 2 + DB);
        end
        fall = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (A_UP === 1'b0 && fall < 0) fall = k;
        end
        checks++;
        if (fall != 2 + DB) begin
            errors++; $display("FAIL debounce_fall: edge %0d expected %0d", fall, 2 + DB);
        end
    endtask

    task automatic test_move_clamp();
        int vals[$];
        int when[$];
        int exp_vals[$];
        int prev;
        int first_tick;
        do_reset();
`ifdef PADDLE_ACCEL_EN
        exp_vals = '{8, 9, 11, 13, 14};
`else
        for (int v = CENTER + 1; v <= MAXPOS; v++) exp_vals.push_back(v);
`endif
        first_tick = 2 + DB + 1;
        while (first_tick % MD != 0) first_tick++;
        B_DOWN_RAW = 1'b1;
        prev = CENTER;
        for (int k = 1; k <= 80; k++) begin
            cycle();
            if (int'(R_PADDLE_POSITION) != prev) begin
                prev = int'(R_PADDLE_POSITION);
                vals.push_back(prev);
                when.push_back(k);
            end
        end
        B_DOWN_RAW = 1'b0;
        checks++;
        if (vals.size() != exp_vals.size()) begin
            errors++; $display("FAIL move_count: %0d position changes expected %0d",
                               vals.size(), exp_vals.size());
        end else begin
            for (int i = 0; i < vals.size(); i++) begin
                checks++;
                if (vals[i] != exp_vals[i]) begin
                    errors++; $display("FAIL move_seq[%0d]: got %0d expected %0d", i, vals[i], exp_vals[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (when[i] - when[i-1] != MD) begin
                        errors++; $display("FAIL move_spacing[%0d]: got %0d cycles expected %0d",
                                           i, when[i] - when[i-1], MD);
                    end
                end
            end
            checks++;
            if (when[0] != first_tick) begin
                errors++; $display("FAIL move_first: edge %0d expected %0d", when[0], first_tick);
            end
        end
        checks++;
        if (R_PADDLE_POSITION !== 11'(MAXPOS) || L_PADDLE_POSITION !== 11'(CENTER)) begin
            errors++; $display("FAIL move_clamp_end: R=%0d L=%0d expected %0d/%0d",
                               R_PADDLE_POSITION, L_PADDLE_POSITION, MAXPOS, CENTER);
        end
    endtask

    task automatic test_up_clamp();
        int min_seen;
        do_reset();
        min_seen = CENTER;
        A_UP_RAW = 1'b1;
        repeat (60) begin
            cycle();
            if (int'(L_PADDLE_POSITION) < min_seen) min_seen = int'(L_PADDLE_POSITION);
        end
        A_UP_RAW = 1'b0;
        checks++;
        if (L_PADDLE_POSITION !== 11'd1 || min_seen != 1) begin
            errors++; $display("FAIL up_clamp: L=%0d min=%0d expected 1/1", L_PADDLE_POSITION, min_seen);
        end
    endtask

    task automatic test_both_held();
        int dev;
        do_reset();
        dev = 0;
        A_UP_RAW = 1'b1;
        A_DOWN_RAW = 1'b1;
        repeat (2 + DB + 10 * MD) begin
            cycle();
            if (L_PADDLE_POSITION !== 11'(CENTER)) dev++;
        end
        checks++;
        if (dev != 0 || A_UP !== 1'b1 || A_DOWN !== 1'b1) begin
            errors++; $display("FAIL both_held: moved %0d cycles, up=%b down=%b expected 0/1/1",
                               dev, A_UP, A_DOWN);
        end
        set_raw('0);
    endtask

    task automatic test_serve_pulse();
        int cnt_a;
        int cnt_b;
        int first;
        do_reset();
        cnt_a = 0; cnt_b = 0; first = -1;
        BTN_A_RAW = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            cycle();
            if (BUTTON_A === 1'b1) begin cnt_a++; if (first < 0) first = k; end
            if (BUTTON_B === 1'b1) cnt_b++;
        end
        BTN_A_RAW = 1'b0;
        checks++;
        if (cnt_a != 1) begin
            errors++; $display("FAIL serve_count: %0d pulse cycles expected 1", cnt_a);
        end
        checks++;
        if (first != 2 + DB + 1) begin
            errors++; $display("FAIL serve_timing: edge %0d expected %0d", first, 2 + DB + 1);
        end
        checks++;
        if (cnt_b != 0) begin
            errors++; $display("FAIL serve_other: BUTTON_B %0d cycles expected 0", cnt_b);
        end
    endtask

    task automatic test_game_over();
        int guard;
        int dev;
        int pulses;
        int moved_at;
        do_reset();
        A_UP_RAW = 1'b1;
        B_DOWN_RAW = 1'b1;
        guard = 0;
        while (!(m_l <= 3 && m_r >= 11) && guard < 60) begin cycle(); guard++; end
        checks++;
        if (guard >= 60) begin
            errors++; $display("FAIL go_setup: timeout after %0d cycles, L=%0d R=%0d", guard, m_l, m_r);
        end
        checks++;
        if (L_PADDLE_POSITION === 11'(CENTER) || R_PADDLE_POSITION === 11'(CENTER)) begin
            errors++; $display("FAIL go_offcentre: L=%0d R=%0d expected both off %0d",
                               L_PADDLE_POSITION, R_PADDLE_POSITION, CENTER);
        end
        GAME_OVER = 1'b1;
        BTN_B_RAW = 1'b1;
        cycle();
        checks++;
        if (L_PADDLE_POSITION !== 11'(CENTER) || R_PADDLE_POSITION !== 11'(CENTER)) begin
            errors++; $display("FAIL go_recentre: L=%0d R=%0d expected %0d", L_PADDLE_POSITION,
                               R_PADDLE_POSITION, CENTER);
        end
        dev = 0; pulses = 0;
        repeat (20) begin
            cycle();
            if (L_PADDLE_POSITION !== 11'(CENTER) || R_PADDLE_POSITION !== 11'(CENTER)) dev++;
            if (BUTTON_B === 1'b1) pulses++;
        end
        checks++;
        if (dev != 0) begin
            errors++; $display("FAIL go_frozen: moved on %0d cycles expected 0", dev);
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL go_serve_pulse: BUTTON_B %0d cycles expected 1", pulses);
        end
        GAME_OVER = 1'b0;
        moved_at = -1;
        for (int k = 1; k <= MD + 1 && moved_at < 0; k++) begin
            cycle();
            if (L_PADDLE_POSITION !== 11'(CENTER)) moved_at = k;
        end
        checks++;
        if (moved_at < 0 || moved_at > MD || L_PADDLE_POSITION !== 11'(CENTER - 1) ||
            R_PADDLE_POSITION !== 11'(CENTER + 1)) begin
            errors++; $display("FAIL go_resume: at=%0d L=%0d R=%0d expected <=%0d/%0d/%0d", moved_at,
                               L_PADDLE_POSITION, R_PADDLE_POSITION, MD, CENTER - 1, CENTER + 1);
        end
        set_raw('0);
    endtask

    task automatic test_reset_midrun();
        int guard;
        do_reset();
        A_UP_RAW = 1'b1;
        guard = 0;
        while (m_l != 3 && guard < 60) begin cycle(); guard++; end
        checks++;
        if (L_PADDLE_POSITION !== 11'd3) begin
            errors++; $display("FAIL midrun_setup: L=%0d expected 3", L_PADDLE_POSITION);
        end
        #2;
        RST = 1'b1;
        A_UP_RAW = 1'b0;
        #1;
        checks++;
        if (L_PADDLE_POSITION !== 11'(CENTER) || R_PADDLE_POSITION !== 11'(CENTER)) begin
            errors++; $display("FAIL midrun_reset_pos: L=%0d R=%0d expected %0d",
                               L_PADDLE_POSITION, R_PADDLE_POSITION, CENTER);
        end
        checks++;
        if ({A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B} !== 6'b0) begin
            errors++; $display("FAIL midrun_reset_levels: got %b expected 000000",
                               {A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B});
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = raw_vec();
            for (int i = 0; i < 6; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            set_raw(r);
            if (GAME_OVER) begin
                if ($urandom_range(0, 9) == 0) GAME_OVER = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                GAME_OVER = 1'b1;
            end
            cycle();
            checks++;
            if ({A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B} !==
                {m_db[0], m_db[1], m_db[3], m_db[4], m_pulse_a, m_pulse_b}) begin
                errors++;
                if (errors < 20) $display("FAIL rand_levels @%0d: got %b expected %b", n,
                    {A_UP, A_DOWN, B_UP, B_DOWN, BUTTON_A, BUTTON_B},
                    {m_db[0], m_db[1], m_db[3], m_db[4], m_pulse_a, m_pulse_b});
            end
            checks++;
            if (L_PADDLE_POSITION !== 11'(m_l) || R_PADDLE_POSITION !== 11'(m_r)) begin
                errors++;
                if (errors < 20) $display("FAIL rand_pos @%0d: got L=%0d R=%0d expected L=%0d R=%0d", n,
                    L_PADDLE_POSITION, R_PADDLE_POSITION, m_l, m_r);
            end
        end
        set_raw('0);
        GAME_OVER = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_move_clamp();
        test_up_clamp();
        test_both_held();
        test_serve_pulse();
        test_game_over();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
